approx_mul_rr_sched: RTL and testbench
======================================

Name: approx_mul_rr_sched

Overview:
- Shares one 8x8 unsigned multiplier datapath between NREQ requesters, using round-robin arbitration.
- Each request selects either the exact product or the 2-row-truncated approximate product (l=2 compensation).
- The datapath is pipelined in two stages with valid/ready handshakes on both sides. Results return tagged with the requester ID.
- The block sits between accelerator lanes and the single shared multiplier resource in the approximate-arithmetic evaluation fabric.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester ID; must be at least ceil(log2(NREQ)).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_x  input  8*NREQ  multiplier operand x; requester i occupies bits [8i+7:8i].
- req_y  input  8*NREQ  multiplicand y, packed the same way.
- req_approx  input  NREQ  1 selects the approximate product, 0 the exact product.
- force_exact  input  1  global override; when 1, every accepted request is computed exact.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  downstream accept.
- rsp_id  output  IDW  index of the requester that issued the result.
- rsp_z  output  16  product.
- rsp_approx  output  1  1 if rsp_z was computed with the approximate function.
- busy  output  1  1 while either pipeline stage holds valid data.

Behaviour:
- Reset, asynchronous and active-high, takes effect immediately:
  - Both stage valid bits clear, so rsp_valid=0 and busy=0.
  - rsp_id, rsp_z and rsp_approx go to 0.
  - The round-robin pointer goes to 0.
  - In-flight data is discarded with no response.
- Pipeline:
  - Stage S1 registers x, y, id and the effective mode (req_approx & ~force_exact).
  - Stage S2 registers z. The S2 register drives the rsp_* outputs.
- Advance rules:
  - adv2 = ~s2_valid | rsp_ready.
  - adv1 = ~s1_valid | adv2.
  - A request is accepted only when adv1=1.
- Arbitration (combinational):
  - Scan starts at the pointer ptr and runs ptr, ptr+1, ... mod NREQ. The first requester with req_valid asserted is granted.
  - req_ready[g]=1 only for the granted g, and only when adv1=1. Otherwise all req_ready bits are 0.
  - A handshake is req_valid[g] & req_ready[g].
  - After a handshake, ptr <= (g+1) mod NREQ. With no handshake, ptr holds.
- Latency and throughput:
  - Accept in cycle N gives rsp_valid in cycle N+2 if there is no backpressure.
  - Throughput is 1 result per cycle.
- Backpressure: while rsp_valid=1 and rsp_ready=0, the S2 outputs hold stable. S1 holds if it is full. Nothing is dropped or duplicated.
- Exact function: z = x*y (16-bit, no overflow).
- Approximate function:
  - c7 = (x[0]&y[7]) | (x[1]&y[6]); c8 = x[1]&y[7].
  - z = ((y*x[7:2]) << 2) + (c8<<8) + (c7<<7), truncated to 16 bits.
  - The maximum value is 64644, so the result never wraps.
- Order: responses emerge in acceptance order.
- A requester must hold x, y and approx stable while req_valid=1 and it is not yet accepted. The scheduler does not check this.
- force_exact is sampled at acceptance. Changing it later does not affect requests already in flight.
- busy = s1_valid | s2_valid.

Test Plan:
- Single request from req 2, x=255, y=255, approx=1, force_exact=0, rsp_ready=1:
  - req_ready[2] pulses.
  - Two cycles later: rsp_valid=1, rsp_id=2, rsp_z=64644, rsp_approx=1.
  - Repeat with approx=0: rsp_z=65025, rsp_approx=0.
- Approximation corners (approx=1):
  - x=3, y=5 gives z=0.
  - x=200, y=100 gives z=20000.
  - x=2, y=128 gives c8=1 and z=256.
  - x=1, y=128 gives c7=1 and z=128.
- All 4 requesters held valid continuously with rsp_ready=1:
  - Grants go 0,1,2,3,0,... one per cycle.
  - rsp_id follows the same order, 2 cycles delayed.
- Backpressure: stream from req 0 and 1, then drop rsp_ready for 5 cycles.
  - rsp_* stays stable throughout.
  - req_ready goes to 0 once S1 and S2 are both full.
  - After release, every result arrives exactly once and in order.
- force_exact=1 with x=255, y=255, approx=1: rsp_z=65025 and rsp_approx=0.
- Assert rst while both stages are valid:
  - rsp_valid drops immediately and busy=0.
  - The first post-reset grant goes to the lowest-index valid requester (ptr=0).
  - No stale response appears.

Source files
------------

// File: rtl/approx_mul_rr_sched.sv
// approx_mul_rr_sched: round-robin scheduler sharing one 2-stage exact/approximate 8x8 multiplier.
module approx_mul_rr_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_x,
  input  logic [8*NREQ-1:0] req_y,
  input  logic [NREQ-1:0]   req_approx,
  input  logic              force_exact,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_z,
  output logic              rsp_approx,
  output logic              busy
);
  logic [IDW-1:0] ptr_q, ptr_d, gnt, idx;
  logic [IDW:0]   sum;
  logic           found, adv1, adv2, hs;
  logic           s1_valid_q, s1_approx_q, s2_valid_q;
  logic [7:0]     s1_x_q, s1_y_q;
  logic [IDW-1:0] s1_id_q;
  logic           c7, c8;
  logic [15:0]    z_exact, z_approx;
  assign adv2 = ~s2_valid_q | rsp_ready;
  assign adv1 = ~s1_valid_q | adv2;
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(k);
      idx = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : IDW'(sum);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end
  assign hs        = found & adv1;
  assign req_ready = hs ? (NREQ'(1) << gnt) : '0;
  assign ptr_d     = hs ? ((gnt == IDW'(NREQ-1)) ? '0 : gnt + 1'b1) : ptr_q;
  // Approximate product drops partial-product rows x[0] and x[1]; c7/c8 compensate the lost top bits.
  assign c7       = (s1_x_q[0] & s1_y_q[7]) | (s1_x_q[1] & s1_y_q[6]);
  assign c8       = s1_x_q[1] & s1_y_q[7];
  assign z_exact  = 16'(s1_x_q) * 16'(s1_y_q);
  assign z_approx = ((16'(s1_y_q) * 16'(s1_x_q[7:2])) << 2) + (16'(c8) << 8) + (16'(c7) << 7);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_id_q     <= '0;
      s1_approx_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      rsp_id      <= '0;
      rsp_z       <= '0;
      rsp_approx  <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      if (adv1) s1_valid_q <= hs;
      if (hs) begin
        s1_x_q      <= req_x[{gnt, 3'b000} +: 8];
        s1_y_q      <= req_y[{gnt, 3'b000} +: 8];
        s1_id_q     <= gnt;
        s1_approx_q <= req_approx[gnt] & ~force_exact;
      end
      if (adv2) s2_valid_q <= s1_valid_q;
      if (adv2 && s1_valid_q) begin
        rsp_id     <= s1_id_q;
        rsp_z      <= s1_approx_q ? z_approx : z_exact;
        rsp_approx <= s1_approx_q;
      end
    end
  end
  assign rsp_valid = s2_valid_q;
  assign busy      = s1_valid_q | s2_valid_q;
endmodule

// File: tb/tb_approx_mul_rr_sched.sv
// tb_approx_mul_rr_sched: scoreboard bench for the round-robin approximate multiplier scheduler.
module tb_approx_mul_rr_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  typedef struct {int id; logic [15:0] z; logic a;} exp_t;
  logic clk = 0, rst = 1;
  logic [NREQ-1:0] rv = '0, ra = '0, req_ready;
  logic [8*NREQ-1:0] rx = '0, ry = '0;
  logic fe = 0, rr = 1;
  logic rsp_valid, rsp_approx, busy;
  logic [IDW-1:0] rsp_id;
  logic [15:0] rsp_z;
  int vectors = 0, errs = 0;
  exp_t q[$];
  int grants[$];
  approx_mul_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(rv), .req_ready(req_ready), .req_x(rx), .req_y(ry),
    .req_approx(ra), .force_exact(fe), .rsp_valid(rsp_valid), .rsp_ready(rr),
    .rsp_id(rsp_id), .rsp_z(rsp_z), .rsp_approx(rsp_approx), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] amul(input logic [7:0] x, input logic [7:0] y, input logic a);
    logic [15:0] s;
    if (!a) return 16'(x) * 16'(y);
    s = 0;
    for (int i = 2; i < 8; i++) if (x[i]) s += 16'(y) << i;
    if (x[1] & y[7]) s += 256;
    if ((x[0] & y[7]) | (x[1] & y[6])) s += 128;
    return s;
  endfunction
  always @(negedge clk) if (!rst && rsp_valid) begin
    if (q.size() == 0) chk("stale", 1, 0);
    else begin
      chk("rsp_id", 32'(rsp_id), q[0].id);
      chk("rsp_z", 32'(rsp_z), 32'(q[0].z));
      chk("rsp_approx", 32'(rsp_approx), 32'(q[0].a));
      if (rr) void'(q.pop_front());
    end
  end
  task automatic cyc(input bit keep);
    logic [NREQ-1:0] hs;
    int g;
    exp_t e;
    @(negedge clk);
    hs = rv & req_ready;
    g = -1;
    for (int i = 0; i < NREQ; i++) if (hs[i]) g = i;
    if (g >= 0) begin
      e.id = g;
      e.a  = ra[g] & ~fe;
      e.z  = amul(rx[8*g +: 8], ry[8*g +: 8], e.a);
      q.push_back(e);
      grants.push_back(g);
    end
    @(posedge clk); #1;
    if (g >= 0) begin
      if (keep) begin
        rx[8*g +: 8] = 8'($urandom);
        ry[8*g +: 8] = 8'($urandom);
        ra[g] = 1'($urandom);
      end else rv[g] = 1'b0;
    end
  endtask
  task automatic drain;
    int n = 0;
    while ((q.size() != 0 || busy) && n < 50) begin cyc(0); n++; end
    chk("drain_timeout", 32'(n >= 50), 0);
    chk("drain_left", q.size(), 0);
  endtask
  task automatic do_reset;
    @(posedge clk); #1;
    rst = 1; rv = '0; rr = 1; fe = 0;
    q.delete(); grants.delete();
    @(posedge clk); #1;
    rst = 0;
  endtask
  task automatic single(input int id, input logic [7:0] x, input logic [7:0] y, input logic a, input logic f, input logic [15:0] zx);
    rx[8*id +: 8] = x; ry[8*id +: 8] = y; ra[id] = a; fe = f; rv[id] = 1;
    grants.delete();
    cyc(0);
    chk("single_grant_n", grants.size(), 1);
    if (grants.size() == 1) chk("single_grant", grants[0], id);
    @(negedge clk) chk("lat1_valid", 32'(rsp_valid), 0);
    @(negedge clk) chk("lat2_valid", 32'(rsp_valid), 1);
    chk("single_z", 32'(rsp_z), 32'(zx));
    @(posedge clk); #1;
    fe = 0;
    drain;
  endtask
  initial begin
    #1;
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_z", 32'(rsp_z), 0);
    chk("rst_ready", 32'(req_ready), 0);
    do_reset;
    single(2, 255, 255, 1, 0, 64644);
    single(2, 255, 255, 0, 0, 65025);
    single(1, 3, 5, 1, 0, 0);
    single(0, 200, 100, 1, 0, 20000);
    single(3, 2, 128, 1, 0, 256);
    single(2, 1, 128, 1, 0, 128);
    single(1, 255, 255, 1, 1, 65025);
    do_reset;
    for (int i = 0; i < NREQ; i++) begin
      rx[8*i +: 8] = 8'($urandom); ry[8*i +: 8] = 8'($urandom); ra[i] = 1'($urandom);
    end
    rv = '1;
    repeat (10) cyc(1);
    rv = '0;
    chk("rr_count", grants.size(), 10);
    foreach (grants[i]) chk("rr_order", grants[i], i % NREQ);
    drain;
    do_reset;
    rv = 4'b0011;
    repeat (4) cyc(1);
    rr = 0;
    repeat (5) cyc(1);
    chk("bp_ready", 32'(req_ready), 0);
    chk("bp_valid", 32'(rsp_valid), 1);
    rv = '0; rr = 1;
    drain;
    rv = '1; rr = 0;
    repeat (4) cyc(1);
    chk("pre_rst_busy", 32'(busy), 1);
    #2 rst = 1;
    #1;
    chk("arst_valid", 32'(rsp_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    q.delete(); grants.delete();
    rv = 4'b1010; rr = 1;
    @(posedge clk); #1;
    rst = 0;
    cyc(0);
    chk("post_rst_grant_n", grants.size(), 1);
    if (grants.size() > 0) chk("post_rst_grant", grants[0], 1);
    rv = '0;
    drain;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end
endmodule
